// File: rtl/cl_mt_state_machine.sv
// Multi-context run-state controller: per-context IDLE/RUN/ERR state plus a
// round-robin issue pointer over the contexts that are running.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | context parked, waiting for a network wake
// RUN   | context eligible for issue
// ERR   | context faulted; left only through a clear command
// ILL   | unreachable encoding; recovered to ERR on the next edge
module cl_mt_state_machine #(
  parameter int NUM_THREADS = 4,
  parameter int THREAD_W    = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     wake_valid_i,
  input  logic [THREAD_W-1:0]      wake_thread_i,
  input  logic                     clear_valid_i,
  input  logic [THREAD_W-1:0]      clear_thread_i,
  input  logic                     retire_valid_i,
  input  logic                     retire_is_wait_i,
  input  logic                     exception_i,
  input  logic                     stall_i,
  output logic [2*NUM_THREADS-1:0] state_o,
  output logic [THREAD_W-1:0]      issue_thread_o,
  output logic                     issue_valid_o,
  output logic                     any_run_o,
  output logic                     wake_drop_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_ERR  = 2'b10,
    ST_ILL  = 2'b11
  } ctx_state_e;

  logic [2*NUM_THREADS-1:0] state_q, state_n;
  logic [THREAD_W-1:0]      ptr_q, ptr_n, scan_ptr;
  logic                     wake_drop_q, wake_drop_n;
  logic [1:0]               cur_p;
  logic                     ret, scan_found, any_run;
  int                       scan_idx;

  always_comb begin
    cur_p   = ST_IDLE;
    any_run = 1'b0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (ptr_q == THREAD_W'(t)) cur_p = state_q[2*t +: 2];
      if (state_q[2*t +: 2] == ST_RUN) any_run = 1'b1;
    end
  end

  assign ret = retire_valid_i & (cur_p == ST_RUN) & ~stall_i;

  always_comb begin
    state_n = state_q;
    for (int t = 0; t < NUM_THREADS; t++) begin
      case (state_q[2*t +: 2])
        ST_IDLE: begin
          if (wake_valid_i && wake_thread_i == THREAD_W'(t)) state_n[2*t +: 2] = ST_RUN;
        end
        ST_RUN: begin
          // exception outranks WAIT on the same retiring instruction
          if (ret && ptr_q == THREAD_W'(t)) begin
            if (exception_i)           state_n[2*t +: 2] = ST_ERR;
            else if (retire_is_wait_i) state_n[2*t +: 2] = ST_IDLE;
          end
        end
        ST_ERR: begin
          if (clear_valid_i && clear_thread_i == THREAD_W'(t)) state_n[2*t +: 2] = ST_IDLE;
        end
        default: state_n[2*t +: 2] = ST_ERR;
      endcase
    end
  end

  // The only way a wake can be lost: it targets the issuing context as it parks.
  assign wake_drop_n = ret & retire_is_wait_i & ~exception_i &
                       wake_valid_i & (wake_thread_i == ptr_q);

  // Scan starts after the pointer and visits the current context last.
  always_comb begin
    scan_found = 1'b0;
    scan_ptr   = ptr_q;
    scan_idx   = 0;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      scan_idx = (int'(ptr_q) + i) % NUM_THREADS;
      if (!scan_found && state_n[2*scan_idx +: 2] == ST_RUN) begin
        scan_found = 1'b1;
        scan_ptr   = THREAD_W'(scan_idx);
      end
    end
    ptr_n = ptr_q;
    if ((ret || cur_p != ST_RUN) && scan_found) ptr_n = scan_ptr;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= '0;
      ptr_q       <= '0;
      wake_drop_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      ptr_q       <= ptr_n;
      wake_drop_q <= wake_drop_n;
    end
  end

  assign state_o        = state_q;
  assign issue_thread_o = ptr_q;
  assign issue_valid_o  = (cur_p == ST_RUN);
  assign any_run_o      = any_run;
  assign wake_drop_o    = wake_drop_q;

endmodule

// File: tb/tb_cl_mt_state_machine.sv
// Scoreboard bench for cl_mt_state_machine (4 contexts): each driven cycle
// queues the hand-derived post-edge outputs, compared on the following negedge.
module tb_cl_mt_state_machine;

  logic       clk;
  logic       n_reset;
  logic       wake_valid_i, clear_valid_i;
  logic [1:0] wake_thread_i, clear_thread_i;
  logic       retire_valid_i, retire_is_wait_i, exception_i, stall_i;
  logic [7:0] state_o;
  logic [1:0] issue_thread_o;
  logic       issue_valid_o, any_run_o, wake_drop_o;

  int checks;
  int failures;

  typedef struct {
    string      tag;
    logic [7:0] state;
    logic [1:0] ptr;
    logic       vld;
    logic       any;
    logic       drop;
  } exp_t;

  exp_t exp_q[$];

  cl_mt_state_machine #(.NUM_THREADS(4)) dut (
    .clk              (clk),
    .n_reset          (n_reset),
    .wake_valid_i     (wake_valid_i),
    .wake_thread_i    (wake_thread_i),
    .clear_valid_i    (clear_valid_i),
    .clear_thread_i   (clear_thread_i),
    .retire_valid_i   (retire_valid_i),
    .retire_is_wait_i (retire_is_wait_i),
    .exception_i      (exception_i),
    .stall_i          (stall_i),
    .state_o          (state_o),
    .issue_thread_o   (issue_thread_o),
    .issue_valid_o    (issue_valid_o),
    .any_run_o        (any_run_o),
    .wake_drop_o      (wake_drop_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle_inputs();
    wake_valid_i = 0; wake_thread_i = 0; clear_valid_i = 0; clear_thread_i = 0;
    retire_valid_i = 0; retire_is_wait_i = 0; exception_i = 0; stall_i = 0;
  endtask

  // Drive one cycle at a negedge, queue the expected outputs after the edge.
  task automatic step(input string tag,
                      input logic wv, input logic [1:0] wt,
                      input logic cv, input logic [1:0] ct,
                      input logic rv, input logic rw, input logic ex, input logic st,
                      input logic [7:0] es, input logic [1:0] ep,
                      input logic ev, input logic ea, input logic ed);
    exp_t e;
    wake_valid_i = wv; wake_thread_i = wt; clear_valid_i = cv; clear_thread_i = ct;
    retire_valid_i = rv; retire_is_wait_i = rw; exception_i = ex; stall_i = st;
    e.tag = tag; e.state = es; e.ptr = ep; e.vld = ev; e.any = ea; e.drop = ed;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check_eq({e.tag, "_state"}, 32'(state_o), 32'(e.state));
      check_eq({e.tag, "_ptr"},   32'(issue_thread_o), 32'(e.ptr));
      check_eq({e.tag, "_vld"},   32'(issue_valid_o), 32'(e.vld));
      check_eq({e.tag, "_any"},   32'(any_run_o), 32'(e.any));
      check_eq({e.tag, "_drop"},  32'(wake_drop_o), 32'(e.drop));
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    n_reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check_eq("rst_state", 32'(state_o), 0);
    check_eq("rst_ptr",   32'(issue_thread_o), 0);
    check_eq("rst_vld",   32'(issue_valid_o), 0);
    check_eq("rst_any",   32'(any_run_o), 0);
    check_eq("rst_drop",  32'(wake_drop_o), 0);
    n_reset = 1'b1;

    //    tag          wv wt  cv ct  rv rw ex st  state  ptr vld any drop
    step("wake0",      1, 0,  0, 0,  0, 0, 0, 0,  8'h01, 0,  1,  1,  0);
    step("wake2",      1, 2,  0, 0,  0, 0, 0, 0,  8'h11, 0,  1,  1,  0);
    step("wake3",      1, 3,  0, 0,  0, 0, 0, 0,  8'h51, 0,  1,  1,  0);
    // issue order 0 -> 2 -> 3 -> 0 -> 2 -> 3 -> 0 -> 2, context 1 skipped
    step("rr_a",       0, 0,  0, 0,  1, 0, 0, 0,  8'h51, 2,  1,  1,  0);
    step("rr_b",       0, 0,  0, 0,  1, 0, 0, 0,  8'h51, 3,  1,  1,  0);
    step("rr_c",       0, 0,  0, 0,  1, 0, 0, 0,  8'h51, 0,  1,  1,  0);
    step("rr_d",       0, 0,  0, 0,  1, 0, 0, 0,  8'h51, 2,  1,  1,  0);
    step("rr_e",       0, 0,  0, 0,  1, 0, 0, 0,  8'h51, 3,  1,  1,  0);
    step("rr_f",       0, 0,  0, 0,  1, 0, 0, 0,  8'h51, 0,  1,  1,  0);
    step("rr_g",       0, 0,  0, 0,  1, 0, 0, 0,  8'h51, 2,  1,  1,  0);
    // context 2 parks on WAIT while a wake targets it: wake lost
    step("wait_drop",  1, 2,  0, 0,  1, 1, 0, 0,  8'h41, 3,  1,  1,  1);
    step("drop_clr",   0, 0,  0, 0,  0, 0, 0, 0,  8'h41, 3,  1,  1,  0);
    // exception held under stall, takes effect only once stall drops
    step("stall_ex1",  0, 0,  0, 0,  1, 0, 1, 1,  8'h41, 3,  1,  1,  0);
    step("stall_ex2",  0, 0,  0, 0,  1, 0, 1, 1,  8'h41, 3,  1,  1,  0);
    step("stall_ex3",  0, 0,  0, 0,  1, 0, 1, 1,  8'h41, 3,  1,  1,  0);
    step("ex_err3",    0, 0,  0, 0,  1, 0, 1, 0,  8'h81, 0,  1,  1,  0);
    // drive context 1 into ERR, then exercise wake/clear recovery
    step("wake1",      1, 1,  0, 0,  0, 0, 0, 0,  8'h85, 0,  1,  1,  0);
    step("ret0",       0, 0,  0, 0,  1, 0, 0, 0,  8'h85, 1,  1,  1,  0);
    step("ex_err1",    0, 0,  0, 0,  1, 0, 1, 0,  8'h89, 0,  1,  1,  0);
    step("err_wake1",  1, 1,  0, 0,  0, 0, 0, 0,  8'h89, 0,  1,  1,  0);
    step("clear1",     0, 0,  1, 1,  0, 0, 0, 0,  8'h81, 0,  1,  1,  0);
    step("wait0",      0, 0,  0, 0,  1, 1, 0, 0,  8'h80, 0,  0,  0,  0);
    step("rewake1",    1, 1,  0, 0,  0, 0, 0, 0,  8'h84, 1,  1,  1,  0);
    // simultaneous wake and clear to different contexts, then to the same one
    step("wk0_clr3",   1, 0,  1, 3,  0, 0, 0, 0,  8'h05, 1,  1,  1,  0);
    step("wk2_clr2",   1, 2,  1, 2,  0, 0, 0, 0,  8'h15, 1,  1,  1,  0);

    // backdoor: illegal encoding on context 0 must recover to ERR
    dut.state_q[1:0] = 2'b11;
    step("illegal0",   0, 0,  0, 0,  0, 0, 0, 0,  8'h16, 1,  1,  1,  0);

    // asynchronous reset mid-cycle with stimulus active
    wake_valid_i = 1; wake_thread_i = 3; retire_valid_i = 1;
    #2;
    n_reset = 1'b0;
    #1;
    check_eq("arst_state", 32'(state_o), 0);
    check_eq("arst_ptr",   32'(issue_thread_o), 0);
    check_eq("arst_vld",   32'(issue_valid_o), 0);
    check_eq("arst_any",   32'(any_run_o), 0);
    check_eq("arst_drop",  32'(wake_drop_o), 0);
    idle_inputs();
    @(negedge clk);
    n_reset = 1'b1;
    step("post_rst",   1, 3,  0, 0,  0, 0, 0, 0,  8'h40, 3,  1,  1,  0);

    check_eq("queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cl_mt_state_machine.md
# cl_mt_state_machine

Multi-context successor to the core run-state controller: holds an independent IDLE/RUN/ERR state for each of `NUM_THREADS` hardware contexts and picks which running context issues next, round-robin. It sits between the network PC-write/command decoder and the fetch/issue stage. It consumes the retire-side decode (WAIT, exception, stall) for the issuing context. Unlike the single-context controller, ERR is recoverable through a per-context clear command, and a wake that loses to a simultaneous WAIT is flagged.

## Interface
Parameters:
- `NUM_THREADS`, default 4: number of contexts; legal range 1..16.
- `THREAD_W`, default `max(1,$clog2(NUM_THREADS))`: width of a context index.

Ports:
- `clk` input, 1: the single clock.
- `n_reset` input, 1: asynchronous, active-low reset.
- `wake_valid_i` input, 1: network PC-write command that wakes a context.
- `wake_thread_i` input, `THREAD_W`: target context of the wake.
- `clear_valid_i` input, 1: error-clear command.
- `clear_thread_i` input, `THREAD_W`: target context of the clear.
- `retire_valid_i` input, 1: an instruction of context `issue_thread_o` completes this cycle.
- `retire_is_wait_i` input, 1: the retiring instruction decodes as `kWAIT`.
- `exception_i` input, 1: the retiring instruction faulted.
- `stall_i` input, 1: the pipeline is stalled; retire and exception are ignored.
- `state_o` output, `2*NUM_THREADS`: packed per-context state, context t at bits [2t+1:2t]. Encoding: IDLE=00, RUN=01, ERR=10.
- `issue_thread_o` output, `THREAD_W`: round-robin pointer.
- `issue_valid_o` output, 1: the context at `issue_thread_o` is in RUN.
- `any_run_o` output, 1: OR over all contexts of (state==RUN).
- `wake_drop_o` output, 1: registered one-cycle pulse, set when a wake was discarded by a same-cycle WAIT.

## Operation
- Effective retire: `ret = retire_valid_i & issue_valid_o & ~stall_i`. It applies only to context `p = issue_thread_o`.
- Per-context next state:
  - IDLE: a wake addressed to t moves it to RUN. Otherwise it stays IDLE; a clear addressed to an IDLE context has no effect.
  - RUN with t==p and `ret`:
    - If `exception_i` is high, go to ERR. Exception has priority over WAIT.
    - Otherwise, if `retire_is_wait_i` is high, go to IDLE.
    - Otherwise stay in RUN.
  - RUN in every other case: stay in RUN. A wake addressed to a running context is ignored, with no drop pulse.
  - ERR: a clear addressed to t moves it to IDLE. A wake does not leave ERR.
  - Encoding 11 is illegal and goes to ERR on the next edge.
- `exception_i` while `stall_i` is high is ignored: the instruction finishes before the exception takes effect.
- Wake to context p in the same cycle as `ret` with WAIT and no exception: the context goes IDLE and the wake is lost. `wake_drop_o` is 1 in the following cycle.
- Wake and clear on the same cycle to different contexts: both apply. Both aimed at the same context: only the rule for its current state applies.
- Pointer update:
  - Compute `state_n` for all contexts first.
  - Starting at p+1 and wrapping modulo `NUM_THREADS`, scan for the first context with `state_n==RUN`. p itself is checked last.
  - The pointer loads that context when `ret` is high or when the state at p is not RUN.
  - If no context will be RUN, the pointer holds.
  - With `NUM_THREADS=1` the pointer is always 0.
- `issue_valid_o` and `any_run_o` are combinational decodes of the registered state and pointer.

## Timing
- Reset (asynchronous, while `n_reset`=0):
  - All contexts IDLE; `state_o`=0.
  - `issue_thread_o`=0.
  - `issue_valid_o`=0, `any_run_o`=0, `wake_drop_o`=0.
  - Reset mid-operation discards all in-flight state immediately.
- Wake at edge n: the context reads RUN in cycle n+1. If it is the only running context, `issue_thread_o` points to it and `issue_valid_o`=1 in cycle n+1 (one-cycle latency).
- WAIT or exception retiring at edge n: the new state is visible in cycle n+1. In the same cycle n+1 the pointer has already moved to the next RUN context.
- Stall: while `stall_i` is high, the state of p and the pointer hold. Wakes and clears are still accepted.
- Round-robin fairness: with k contexts in RUN and `ret` every cycle, each context issues exactly once in every k consecutive retires.

## Test plan
- Reset with stimulus active: assert `n_reset`=0 mid-stream. Required: `state_o`=0, `issue_thread_o`=0 and `issue_valid_o`=0 asynchronously, before the next edge.
- Wake contexts 0, 2 and 3 (of 4), then hold `retire_valid_i`=1 with no stall. Required: issue order 0,2,3,0,2,3; context 1 is never selected.
- Context 2 issuing, with `retire_is_wait_i`=1 and a wake to context 2 in the same cycle. Required: `state_o[5:4]`=00 and `wake_drop_o`=1 next cycle; the pointer moves to 3.
- `exception_i`=1 with `stall_i`=1 for 3 cycles, then `stall_i`=0 with the exception still high. Required: ERR appears only the cycle after the stall drops.
- Context 1 in ERR: a wake to context 1 has no effect; a clear to context 1 gives IDLE; a subsequent wake gives RUN with `issue_valid_o`=1.
- Force state encoding 11 on context 0 through a backdoor. Required: ERR (10) on the next edge.
